// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, fault causes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_FUNCT3, ERR_RANGE, ERR_ALIGN} err_cause_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Only one cause is reported; an illegal opcode outranks range, which outranks alignment.
  function automatic err_cause_t classify(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [31:0] depth);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2])) return ERR_FUNCT3;
    if ({2'b00, addr[31:2]} >= depth) return ERR_RANGE;
    if ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00))
      return ERR_ALIGN;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane enables, store-data replication and load extraction/extension for one word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = rword >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? rword[31:16] : rword[15:0];
    be      = 4'h0;
    wword   = '0;
    rdata   = '0;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wword = {4{wdata[7:0]}};
        rdata = funct3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = funct3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      end
      default: begin
        be    = 4'hF;
        wword = wdata;
        rdata = rword;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dmem.sv
// Three-state load/store unit over a byte-lane data memory.
// Define LSU_DMEM_ERR_CNT_EN to add the saturating err_count output.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
`ifdef LSU_DMEM_ERR_CNT_EN
  output logic            rsp_err,
  output logic [15:0]     err_count
`else
  output logic            rsp_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  state_t          state, state_nx;
  req_t            r;
  err_cause_t      cause;
  logic            fault;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [31:0]     wword, ld;
  logic [XLEN-1:0] mem [DEPTH];

  assign cause = classify(r.we, r.funct3, r.addr, 32'(DEPTH));
  assign fault = (cause != ERR_NONE);
  assign idx   = r.addr[AW+1:2];

  lsu_align u_align (
    .funct3 (r.funct3),
    .off    (r.addr[1:0]),
    .wdata  (r.wdata),
    .rword  (mem[idx]),
    .be     (be),
    .wword  (wword),
    .rdata  (ld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r <= '0;
    else if (req_valid && req_ready) r <= '{req_we, req_funct3, req_addr, req_wdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_err   <= fault;
      rsp_rdata <= (fault || r.we) ? '0 : ld;
    end
  end

  // Stores commit only at the ACCESS edge, so a reset before it drops the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ACCESS && r.we && !fault) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

`ifdef LSU_DMEM_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_count <= '0;
    else if (rsp_valid && rsp_ready && rsp_err && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lsu_dmem.sv
// Self-checking bench for lsu_dmem: directed vectors, faults, backpressure, reset abort, random vs byte model.
module tb_lsu_dmem;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
`ifdef LSU_DMEM_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_err_model = 0;
  logic [7:0] mm [DEPTH*4];

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  always #5 clk = ~clk;

  lsu_dmem #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
`ifdef LSU_DMEM_ERR_CNT_EN
    .rsp_err    (rsp_err),
    .err_count  (err_count)
`else
    .rsp_err    (rsp_err)
`endif
  );

  // Reference: a flat byte array, accesses decided from size/alignment arithmetic.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int size;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4) ||
          (addr % 32'(size) != 0) || (addr / 4 >= 32'(DEPTH));
    rd = '0;
    if (err) n_err_model++;
    else if (we) begin
      for (int i = 0; i < size; i++) mm[addr + 32'(i)] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) rd[8*i +: 8] = mm[addr + 32'(i)];
      if (f3 < 3'd4 && size == 1 && rd[7])  rd[31:8]  = '1;
      if (f3 < 3'd4 && size == 2 && rd[15]) rd[31:16] = '1;
    end
  endfunction

  // Drives one request and waits (bounded) for its response; lat counts cycles after acceptance.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic err,
                      output int lat);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = 'x; err = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; err = rsp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;
    #12;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
`ifdef LSU_DMEM_ERR_CNT_EN
    n_checks++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
`endif
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_vectors(input string name, input vec_t v[$]);
    logic [31:0] rd, mrd;
    logic        err, merr;
    int          lat;
    foreach (v[k]) begin
      model(v[k].we, v[k].f3, v[k].addr, v[k].wd, mrd, merr);
      xact(v[k].we, v[k].f3, v[k].addr, v[k].wd, rd, err, lat);
      n_checks++;
      if (rd !== v[k].rd || err !== v[k].err || lat != 2) begin
        n_fail++;
        $display("FAIL %s[%0d] addr=%h got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=2",
                 name, k, v[k].addr, rd, err, lat, v[k].rd, v[k].err);
      end
    end
  endtask

  task automatic test_directed;
    vec_t v[$];
    v.push_back({1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0,        1'b0});
    v.push_back({1'b0, 3'b010, 32'h8, 32'h0,        32'hDEADBEEF, 1'b0});
    v.push_back({1'b1, 3'b000, 32'h9, 32'h55,       32'h0,        1'b0});
    v.push_back({1'b0, 3'b000, 32'h9, 32'h0,        32'h00000055, 1'b0});
    v.push_back({1'b0, 3'b010, 32'h8, 32'h0,        32'hDEAD55EF, 1'b0});
    v.push_back({1'b0, 3'b100, 32'hB, 32'h0,        32'h000000DE, 1'b0});
    v.push_back({1'b0, 3'b000, 32'hB, 32'h0,        32'hFFFFFFDE, 1'b0});
    v.push_back({1'b1, 3'b001, 32'hA, 32'h8001,     32'h0,        1'b0});
    v.push_back({1'b0, 3'b001, 32'hA, 32'h0,        32'hFFFF8001, 1'b0});
    v.push_back({1'b0, 3'b101, 32'hA, 32'h0,        32'h00008001, 1'b0});
    test_vectors("directed", v);
  endtask

  task automatic test_errors;
    vec_t v[$];
    v.push_back({1'b0, 3'b010, 32'h6,   32'h0,        32'h0, 1'b1});
    v.push_back({1'b1, 3'b001, 32'h3,   32'hFFFF,     32'h0, 1'b1});
    v.push_back({1'b0, 3'b010, 32'h100, 32'h0,        32'h0, 1'b1});
    test_vectors("fault", v);
`ifdef LSU_DMEM_ERR_CNT_EN
    n_checks++; if (err_count !== 16'd3) begin n_fail++; $display("FAIL err_count_after_faults got %0d want 3", err_count); end
`endif
    v.delete();
    v.push_back({1'b1, 3'b100, 32'h10,  32'hAB,       32'h0, 1'b1});
    v.push_back({1'b0, 3'b011, 32'h10,  32'h0,        32'h0, 1'b1});
    v.push_back({1'b1, 3'b111, 32'h10,  32'h1234,     32'h0, 1'b1});
    v.push_back({1'b0, 3'b010, 32'h0,   32'h0,        32'h0, 1'b0});
    v.push_back({1'b0, 3'b010, 32'h4,   32'h0,        32'h0, 1'b0});
    v.push_back({1'b0, 3'b010, 32'h8,   32'h0,        32'h800155EF, 1'b0});
    v.push_back({1'b0, 3'b010, 32'h10,  32'h0,        32'h0, 1'b0});
    test_vectors("fault_mem", v);
  endtask

  task automatic test_backpressure;
    logic [31:0] rd0, rd, mrd;
    logic        err, merr;
    int          lat;
    bit          seen;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    rd0 = rsp_rdata;
    n_checks++; if (!seen || rd0 !== 32'h800155EF) begin n_fail++; $display("FAIL bp_first_rdata got %h valid=%b want 800155ef", rd0, seen); end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h0;
      end else req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got valid=%b rdata=%h ready=%b want 1 %h 0", c, rsp_valid, rsp_rdata, req_ready, rd0);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
    model(1'b0, 3'b010, 32'h8, 32'h0, mrd, merr);
    xact(1'b0, 3'b010, 32'h8, 32'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h800155EF || err !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_store got %h err=%b want 800155ef 0", rd, err); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd;
    logic        err;
    int          lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 reset = 1'b1;
    for (int i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;
    n_err_model = 0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_in_reset got valid=%b want 0", rsp_valid); end
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle[%0d] got valid=%b ready=%b want 0 1", c, rsp_valid, req_ready); end
    end
    xact(1'b0, 3'b010, 32'h4, 32'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h0 || err !== 1'b0 || lat != 2) begin n_fail++; $display("FAIL abort_lw4 got %h err=%b lat=%0d want 0 0 2", rd, err, lat); end
    xact(1'b0, 3'b010, 32'h8, 32'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL abort_cleared_lw8 got %h err=%b want 0 0", rd, err); end
`ifdef LSU_DMEM_ERR_CNT_EN
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL abort_err_count got %0d want 0", err_count); end
`endif
  endtask

  task automatic test_random;
    logic [2:0]  codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [31:0] rd, mrd, addr, wd;
    logic        err, merr, we;
    logic [2:0]  f3;
    int          lat, sel;
    for (int k = 0; k < 80; k++) begin
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 10);
      f3  = (sel > 7) ? 3'd2 : codes[sel];
      case ($urandom_range(0, 7))
        0:       addr = $urandom;
        1, 2:    addr = $urandom_range(DEPTH*4 - 16, DEPTH*4 + 15);
        default: addr = $urandom_range(0, 47);
      endcase
      wd = $urandom;
      model(we, f3, addr, wd, mrd, merr);
      xact(we, f3, addr, wd, rd, err, lat);
      n_checks++;
      if (rd !== mrd || err !== merr || lat != 2) begin
        n_fail++;
        $display("FAIL random[%0d] we=%b f3=%0d addr=%h got %h err=%b lat=%0d want %h err=%b lat=2",
                 k, we, f3, addr, rd, err, lat, mrd, merr);
      end
    end
`ifdef LSU_DMEM_ERR_CNT_EN
    n_checks++; if (err_count !== 16'(n_err_model)) begin n_fail++; $display("FAIL random_err_count got %0d want %0d", err_count, n_err_model); end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
